// File: rtl/sram_march_bist.sv
// March C- built-in self test for a group of SRAM macros that share address
// and data buses. While idle the functional controls pass straight through to
// the macros. While running, the engine tests one macro at a time with
// up(w0); up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0); up(r0).
// Read data is compared one cycle after the read is issued.
// Optional feature: define SRAM_BIST_DIAG_EN to latch the first mismatch
// (macro, address, expected, observed) on the fail_* diagnostic ports.
// Handshake: start is a level sampled on clk; done is a status level held in
// DONE until the next start or reset, and busy is high exactly while running.
module sram_march_bist #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_MACROS = 2,
    parameter int MW         = (NUM_MACROS > 1) ? $clog2(NUM_MACROS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [NUM_MACROS-1:0]            func_cen,
    input  logic                             func_gwen,
    input  logic [DATA_WIDTH-1:0]            func_wen,
    input  logic [ADDR_WIDTH-1:0]            func_a,
    input  logic [DATA_WIDTH-1:0]            func_d,
    output logic [NUM_MACROS-1:0]            sram_cen,
    output logic                             sram_gwen,
    output logic [DATA_WIDTH-1:0]            sram_wen,
    output logic [ADDR_WIDTH-1:0]            sram_a,
    output logic [DATA_WIDTH-1:0]            sram_d,
    input  logic [NUM_MACROS*DATA_WIDTH-1:0] sram_q,
    output logic                             busy,
    output logic                             done,
    output logic                             fail,
    output logic [MW-1:0]                    fail_macro,
    output logic [ADDR_WIDTH-1:0]            fail_addr,
    output logic [DATA_WIDTH-1:0]            fail_exp,
    output logic [DATA_WIDTH-1:0]            fail_got,
    output logic [1:0]                       state_dbg
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX   = '1;
    localparam logic [MW-1:0]         MACRO_LAST = MW'(NUM_MACROS - 1);

    state_t                  state, next_state;
    logic [MW-1:0]           macro_idx;
    logic [2:0]              elem;        // March element 0..5
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    phase;       // 0: first op at this address, 1: second op
    logic                    ops_done;    // every operation issued, draining the compare
    logic                    tail;        // last compare has been taken
    logic                    pipe_valid;
    logic [DATA_WIDTH-1:0]   pipe_exp;
    logic [MW-1:0]           pipe_macro;
    logic                    fail_r;
    logic [DATA_WIDTH-1:0]   q_word [NUM_MACROS];

    logic issuing, start_run, is_read, is_down, rd_bg, wr_bg;
    logic addr_last_op, elem_last_addr, mismatch;

    for (genvar m = 0; m < NUM_MACROS; m++) begin : g_q_split
        assign q_word[m] = sram_q[m*DATA_WIDTH +: DATA_WIDTH];
    end

    // Operation decode for the current element/phase position.
    assign issuing        = (state == S_RUN) && !ops_done;
    assign start_run      = (state != S_RUN) && start;
    assign is_read        = (elem != 3'd0) && !phase;
    assign is_down        = (elem == 3'd3) || (elem == 3'd4);
    assign rd_bg          = (elem == 3'd2) || (elem == 3'd4);
    assign wr_bg          = (elem == 3'd1) || (elem == 3'd3);
    assign addr_last_op   = (elem == 3'd0) || (elem == 3'd5) || phase;
    assign elem_last_addr = is_down ? (addr == '0) : (addr == ADDR_MAX);
    assign mismatch       = (state == S_RUN) && pipe_valid && (q_word[pipe_macro] != pipe_exp);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state logic; start is ignored while running.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start)             next_state = S_RUN;
            S_RUN:   if (ops_done && tail)  next_state = S_DONE;
            S_DONE:  if (start)             next_state = S_RUN;
            default:                        next_state = S_IDLE;
        endcase
    end

    // Outputs: status flags and the pass-through / BIST mux to the macros.
    always_comb begin
        busy      = (state == S_RUN);
        done      = (state == S_DONE);
        fail      = fail_r;
        state_dbg = state;
        sram_cen  = func_cen;
        sram_gwen = func_gwen;
        sram_wen  = func_wen;
        sram_a    = func_a;
        sram_d    = func_d;
        if (busy) begin
            sram_cen  = '1;
            sram_gwen = 1'b1;
            sram_wen  = '1;
            sram_a    = '0;
            sram_d    = '0;
            if (issuing) begin
                sram_cen[macro_idx] = 1'b0;
                sram_a              = addr;
                if (!is_read) begin
                    sram_gwen = 1'b0;
                    sram_wen  = '0;
                    sram_d    = {DATA_WIDTH{wr_bg}};
                end
            end
        end
    end

    // March sequencer, read-compare pipeline and sticky fail flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            macro_idx  <= '0;
            elem       <= '0;
            addr       <= '0;
            phase      <= 1'b0;
            ops_done   <= 1'b0;
            tail       <= 1'b0;
            pipe_valid <= 1'b0;
            pipe_exp   <= '0;
            pipe_macro <= '0;
            fail_r     <= 1'b0;
        end else if (start_run) begin
            macro_idx  <= '0;
            elem       <= '0;
            addr       <= '0;
            phase      <= 1'b0;
            ops_done   <= 1'b0;
            tail       <= 1'b0;
            pipe_valid <= 1'b0;
            pipe_exp   <= '0;
            pipe_macro <= '0;
            fail_r     <= 1'b0;
        end else if (state == S_RUN) begin
            pipe_valid <= issuing && is_read;
            pipe_exp   <= {DATA_WIDTH{rd_bg}};
            pipe_macro <= macro_idx;
            if (mismatch) fail_r <= 1'b1;
            if (ops_done) tail <= 1'b1;
            if (issuing) begin
                if (!addr_last_op) begin
                    phase <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    if (!elem_last_addr) begin
                        addr <= is_down ? addr - 1'b1 : addr + 1'b1;
                    end else if (elem == 3'd5) begin
                        elem <= '0;
                        addr <= '0;
                        if (macro_idx == MACRO_LAST) ops_done  <= 1'b1;
                        else                         macro_idx <= macro_idx + 1'b1;
                    end else begin
                        elem <= elem + 3'd1;
                        // Elements 3 and 4 walk downwards from the top address.
                        addr <= (elem == 3'd2 || elem == 3'd3) ? ADDR_MAX : '0;
                    end
                end
            end
        end
    end

`ifdef SRAM_BIST_DIAG_EN
    logic [ADDR_WIDTH-1:0] pipe_addr;
    logic [MW-1:0]         diag_macro;
    logic [ADDR_WIDTH-1:0] diag_addr;
    logic [DATA_WIDTH-1:0] diag_exp, diag_got;

    // Capture the first mismatch of a run; later ones leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_addr  <= '0;
            diag_macro <= '0;
            diag_addr  <= '0;
            diag_exp   <= '0;
            diag_got   <= '0;
        end else if (start_run) begin
            pipe_addr  <= '0;
            diag_macro <= '0;
            diag_addr  <= '0;
            diag_exp   <= '0;
            diag_got   <= '0;
        end else begin
            pipe_addr <= addr;
            if (mismatch && !fail_r) begin
                diag_macro <= pipe_macro;
                diag_addr  <= pipe_addr;
                diag_exp   <= pipe_exp;
                diag_got   <= q_word[pipe_macro];
            end
        end
    end

    assign fail_macro = diag_macro;
    assign fail_addr  = diag_addr;
    assign fail_exp   = diag_exp;
    assign fail_got   = diag_got;
`else
    assign fail_macro = '0;
    assign fail_addr  = '0;
    assign fail_exp   = '0;
    assign fail_got   = '0;
`endif

endmodule

// File: tb/tb_sram_march_bist.sv
// Directed bench for sram_march_bist with two behavioural 4x8 SRAM macros.
// A stuck-at-1 fault on macro 1, address 2, bit 3 can be switched in.
module tb_sram_march_bist;

    localparam int AW = 2;
    localparam int DW = 8;
    localparam int NM = 2;
    localparam int N  = 4;
    localparam int RUN_OPS = NM * 10 * N;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [NM-1:0]  func_cen;
    logic           func_gwen;
    logic [DW-1:0]  func_wen;
    logic [AW-1:0]  func_a;
    logic [DW-1:0]  func_d;
    logic [NM-1:0]  sram_cen;
    logic           sram_gwen;
    logic [DW-1:0]  sram_wen;
    logic [AW-1:0]  sram_a;
    logic [DW-1:0]  sram_d;
    logic [NM*DW-1:0] sram_q;
    logic           busy, done, fail;
    logic [0:0]     fail_macro;
    logic [AW-1:0]  fail_addr;
    logic [DW-1:0]  fail_exp, fail_got;
    logic [1:0]     state_dbg;

    logic [DW-1:0]  mem [NM][N];
    logic [DW-1:0]  q   [NM];
    logic           fault_en = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];

    sram_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_MACROS(NM)) dut (
        .clk(clk), .rst(rst), .start(start),
        .func_cen(func_cen), .func_gwen(func_gwen), .func_wen(func_wen),
        .func_a(func_a), .func_d(func_d),
        .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
        .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q),
        .busy(busy), .done(done), .fail(fail),
        .fail_macro(fail_macro), .fail_addr(fail_addr),
        .fail_exp(fail_exp), .fail_got(fail_got), .state_dbg(state_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    // Behavioural SRAM macros: bit-masked write, registered read.
    assign sram_q = {q[1], q[0]};
    always @(posedge clk) begin
        for (int m = 0; m < NM; m++) begin
            if (!sram_cen[m]) begin
                if (!sram_gwen)
                    mem[m][sram_a] <= (mem[m][sram_a] & sram_wen) | (sram_d & ~sram_wen);
                else
                    q[m] <= mem[m][sram_a] |
                            ((fault_en && m == 1 && sram_a == 2'd2) ? 8'h08 : 8'h00);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected macro-0 op stream: {write, addr, data}; reads carry data 0.
    task automatic build_exp_ops();
        exp_q.delete();
        for (int a = 0; a < N; a++) exp_q.push_back({1'b1, 2'(a), 8'h00});
        for (int a = 0; a < N; a++) begin exp_q.push_back({1'b0, 2'(a), 8'h00}); exp_q.push_back({1'b1, 2'(a), 8'hFF}); end
        for (int a = 0; a < N; a++) begin exp_q.push_back({1'b0, 2'(a), 8'h00}); exp_q.push_back({1'b1, 2'(a), 8'h00}); end
        for (int a = N-1; a >= 0; a--) begin exp_q.push_back({1'b0, 2'(a), 8'h00}); exp_q.push_back({1'b1, 2'(a), 8'hFF}); end
        for (int a = N-1; a >= 0; a--) begin exp_q.push_back({1'b0, 2'(a), 8'h00}); exp_q.push_back({1'b1, 2'(a), 8'h00}); end
        for (int a = 0; a < N; a++) exp_q.push_back({1'b0, 2'(a), 8'h00});
    endtask

    task automatic check_diag(input logic [0:0] m, input logic [AW-1:0] a,
                              input logic [DW-1:0] e, input logic [DW-1:0] g);
        check("fail_macro", fail_macro, m);
        check("fail_addr", fail_addr, a);
        check("fail_exp", fail_exp, e);
        check("fail_got", fail_got, g);
    endtask

    // One start pulse, then watch the full run edge by edge.
    task automatic run_bist(input bit expect_fail, input bit watch_ops);
        logic [10:0] obs;
        logic [10:0] exp_op;
        if (watch_ops) build_exp_ops();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k <= 85; k++) begin
            @(negedge clk);
            if (k == 0 || k == RUN_OPS - 1) check("busy_run", busy, 1);
            if (k == 1) check("fail_cleared", fail, 0);
            if (k < RUN_OPS) check("cen_sel", sram_cen, (k < RUN_OPS/2) ? 2'b10 : 2'b01);
            if (k == RUN_OPS || k == RUN_OPS + 1) check("cen_drain", sram_cen, 2'b11);
            if (watch_ops && k < RUN_OPS/2) begin
                exp_op = exp_q.pop_front();
                obs = {~sram_gwen, sram_a, sram_gwen ? 8'h00 : sram_d};
                check("op_order", obs, exp_op);
            end
            if (k == RUN_OPS + 1) begin
                check("done_early", done, 0);
                check("busy_tail", busy, 1);
            end
            if (k == RUN_OPS + 2) begin
                check("done_rise", done, 1);
                check("busy_end", busy, 0);
                check("fail_end", fail, expect_fail);
            end
            if (k == 85) check("done_hold", done, 1);
        end
    endtask

    initial begin
        int n;
        for (int m = 0; m < NM; m++) for (int a = 0; a < N; a++) mem[m][a] = 8'h00;
        q[0] = 8'h00; q[1] = 8'h00;
        rst = 1'b1; start = 1'b0;
        func_cen = 2'b11; func_gwen = 1'b1; func_wen = 8'hFF; func_a = '0; func_d = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_state", state_dbg, 0);
        check_diag(0, 0, 0, 0);
        rst = 1'b0;

        // Pass-through write then read on macro 0, address 3.
        @(negedge clk);
        func_cen = 2'b10; func_a = 2'h3; func_gwen = 1'b0; func_wen = 8'h00; func_d = 8'h55;
        #1;
        check("pt_cen", sram_cen, 2'b10);
        check("pt_a", sram_a, 2'h3);
        check("pt_gwen", sram_gwen, 0);
        check("pt_wen", sram_wen, 8'h00);
        check("pt_d", sram_d, 8'h55);
        @(negedge clk);
        func_gwen = 1'b1; func_wen = 8'hFF; func_d = 8'h00;
        @(negedge clk);
        check("pt_read", sram_q[7:0], 8'h55);
        func_cen = 2'b00;

        // Clean run with op-order monitoring of macro 0.
        run_bist(1'b0, 1'b1);
        check_diag(0, 0, 0, 0);

        // Stuck-at-1 on macro 1, address 2, bit 3.
        fault_en = 1'b1;
        run_bist(1'b1, 1'b0);
`ifdef SRAM_BIST_DIAG_EN
        check_diag(1, 2, 8'h00, 8'h08);
`else
        check_diag(0, 0, 0, 0);
`endif
        fault_en = 1'b0;

        // Start held high: one run, one-cycle done pulse, then a new run.
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 84; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("held_fail_clr", fail, 0);
                check("held_diag_clr", fail_got, 0);
            end
            if (k == 40) check("held_busy", busy, 1);
            if (k == RUN_OPS + 1) check("held_done_pre", done, 0);
            if (k == RUN_OPS + 2) check("held_done", done, 1);
            if (k == RUN_OPS + 3) begin
                check("held_done_off", done, 0);
                check("held_rerun", busy, 1);
            end
        end
        start = 1'b0;
        n = 0;
        while (!done && n < 200) begin @(negedge clk); n++; end
        check("held_timeout", done, 1);

        // Reset in the middle of a run.
        func_cen = 2'b01; func_gwen = 1'b1;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_fail", fail, 0);
        check("mid_cen", sram_cen, 2'b01);
        check("mid_gwen", sram_gwen, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_idle", state_dbg, 0);
        check("mid_idle_cen", sram_cen, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
